// File: rtl/rs_issue_queue.sv
// rtl/rs_issue_queue.sv - Tomasulo reservation station with CDB wakeup and a registered issue stage
module rs_issue_queue #(
  parameter int DEPTH   = 16,
  parameter int XLEN    = 32,
  parameter int ROB_W   = 4,
  parameter int NUM_CDB = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       rollback,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_v1,
  input  logic [XLEN-1:0]            in_v2,
  input  logic [ROB_W-1:0]           in_q1,
  input  logic [ROB_W-1:0]           in_q2,
  input  logic                       in_q1_need,
  input  logic                       in_q2_need,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [XLEN-1:0]            in_imm,
  input  logic [6:0]                 in_opcode,
  input  logic [2:0]                 in_funct3,
  input  logic                       in_funct7b,
  input  logic [ROB_W-1:0]           in_rob,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]   cdb_rob,
  input  logic [NUM_CDB*XLEN-1:0]    cdb_value,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_v1,
  output logic [XLEN-1:0]            out_v2,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_imm,
  output logic [6:0]                 out_opcode,
  output logic [2:0]                 out_funct3,
  output logic                       out_funct7b,
  output logic [ROB_W-1:0]           out_rob,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] used_q, used_d, q1n_q, q1n_d, q2n_q, q2n_d;
  logic [XLEN-1:0]  v1_q [DEPTH], v1_d [DEPTH], v2_q [DEPTH], v2_d [DEPTH];
  logic [XLEN-1:0]  pc_q [DEPTH], pc_d [DEPTH], imm_q [DEPTH], imm_d [DEPTH];
  logic [ROB_W-1:0] q1_q [DEPTH], q1_d [DEPTH], q2_q [DEPTH], q2_d [DEPTH];
  logic [ROB_W-1:0] rob_q [DEPTH], rob_d [DEPTH];
  logic [6:0]       opc_q [DEPTH], opc_d [DEPTH];
  logic [2:0]       f3_q [DEPTH], f3_d [DEPTH];
  logic [DEPTH-1:0] f7_q, f7_d;

  logic             ov_q, ov_d, of7_q, of7_d;
  logic [XLEN-1:0]  ov1_q, ov1_d, ov2_q, ov2_d, opc_out_q, opc_out_d, oimm_q, oimm_d;
  logic [6:0]       oopc_q, oopc_d;
  logic [2:0]       of3_q, of3_d;
  logic [ROB_W-1:0] orob_q, orob_d;

  logic [XLEN:0]    wk1 [DEPTH], wk2 [DEPTH];
  logic [XLEN:0]    byp1, byp2;
  logic [IDX_W-1:0] alloc_idx, sel_idx;
  logic             alloc_found, sel_found, advance;
  logic [OCC_W-1:0] occ_cnt;

  // Returns {hit, value}; iterating from the top lets the lowest channel win on multiple hits.
  function automatic logic [XLEN:0] cdb_hit(input logic [ROB_W-1:0] tag,
                                            input logic [NUM_CDB-1:0] vld,
                                            input logic [NUM_CDB*ROB_W-1:0] tags,
                                            input logic [NUM_CDB*XLEN-1:0] vals);
    logic [XLEN:0] r;
    r = '0;
    for (int k = NUM_CDB-1; k >= 0; k--) begin
      if (vld[k] && tags[k*ROB_W +: ROB_W] == tag) r = {1'b1, vals[k*XLEN +: XLEN]};
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wk1[i] = cdb_hit(q1_q[i], cdb_valid, cdb_rob, cdb_value);
      wk2[i] = cdb_hit(q2_q[i], cdb_valid, cdb_rob, cdb_value);
    end
  end

  assign byp1 = cdb_hit(in_q1, cdb_valid, cdb_rob, cdb_value);
  assign byp2 = cdb_hit(in_q2, cdb_valid, cdb_rob, cdb_value);

  // Free-slot and select searches look only at registered state, so an entry freed by
  // this cycle's issue is invisible to dispatch until the next cycle.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    sel_found   = 1'b0;
    sel_idx     = '0;
    occ_cnt     = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!used_q[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
      if (used_q[i] && !q1n_q[i] && !q2n_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) occ_cnt = occ_cnt + OCC_W'(used_q[i]);
  end

  assign in_ready  = rdy && alloc_found;
  assign advance   = !ov_q || out_ready;
  assign occupancy = occ_cnt;

  always_comb begin
    used_d = used_q;  q1n_d = q1n_q;  q2n_d = q2n_q;  f7_d = f7_q;
    v1_d = v1_q;  v2_d = v2_q;  pc_d = pc_q;  imm_d = imm_q;
    q1_d = q1_q;  q2_d = q2_q;  rob_d = rob_q;  opc_d = opc_q;  f3_d = f3_q;
    ov_d = ov_q;  ov1_d = ov1_q;  ov2_d = ov2_q;  opc_out_d = opc_out_q;  oimm_d = oimm_q;
    oopc_d = oopc_q;  of3_d = of3_q;  of7_d = of7_q;  orob_d = orob_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (used_q[i] && q1n_q[i] && wk1[i][XLEN]) begin
        v1_d[i]  = wk1[i][XLEN-1:0];
        q1n_d[i] = 1'b0;
      end
      if (used_q[i] && q2n_q[i] && wk2[i][XLEN]) begin
        v2_d[i]  = wk2[i][XLEN-1:0];
        q2n_d[i] = 1'b0;
      end
    end

    if (advance) begin
      ov_d = sel_found;
      if (sel_found) begin
        ov1_d     = v1_q[sel_idx];
        ov2_d     = v2_q[sel_idx];
        opc_out_d = pc_q[sel_idx];
        oimm_d    = imm_q[sel_idx];
        oopc_d    = opc_q[sel_idx];
        of3_d     = f3_q[sel_idx];
        of7_d     = f7_q[sel_idx];
        orob_d    = rob_q[sel_idx];
        used_d[sel_idx] = 1'b0;
      end
    end

    if (in_valid && in_ready) begin
      used_d[alloc_idx] = 1'b1;
      v1_d[alloc_idx]   = (in_q1_need && byp1[XLEN]) ? byp1[XLEN-1:0] : in_v1;
      v2_d[alloc_idx]   = (in_q2_need && byp2[XLEN]) ? byp2[XLEN-1:0] : in_v2;
      q1n_d[alloc_idx]  = in_q1_need && !byp1[XLEN];
      q2n_d[alloc_idx]  = in_q2_need && !byp2[XLEN];
      q1_d[alloc_idx]   = in_q1;
      q2_d[alloc_idx]   = in_q2;
      pc_d[alloc_idx]   = in_pc;
      imm_d[alloc_idx]  = in_imm;
      opc_d[alloc_idx]  = in_opcode;
      f3_d[alloc_idx]   = in_funct3;
      f7_d[alloc_idx]   = in_funct7b;
      rob_d[alloc_idx]  = in_rob;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      used_q <= '0;  q1n_q <= '0;  q2n_q <= '0;  f7_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        v1_q[i] <= '0;  v2_q[i] <= '0;  pc_q[i] <= '0;  imm_q[i] <= '0;
        q1_q[i] <= '0;  q2_q[i] <= '0;  rob_q[i] <= '0;  opc_q[i] <= '0;  f3_q[i] <= '0;
      end
      ov_q <= 1'b0;  ov1_q <= '0;  ov2_q <= '0;  opc_out_q <= '0;  oimm_q <= '0;
      oopc_q <= '0;  of3_q <= '0;  of7_q <= 1'b0;  orob_q <= '0;
    end else if (rollback) begin
      used_q <= '0;
      ov_q   <= 1'b0;
    end else if (rdy) begin
      used_q <= used_d;  q1n_q <= q1n_d;  q2n_q <= q2n_d;  f7_q <= f7_d;
      v1_q <= v1_d;  v2_q <= v2_d;  pc_q <= pc_d;  imm_q <= imm_d;
      q1_q <= q1_d;  q2_q <= q2_d;  rob_q <= rob_d;  opc_q <= opc_d;  f3_q <= f3_d;
      ov_q <= ov_d;  ov1_q <= ov1_d;  ov2_q <= ov2_d;  opc_out_q <= opc_out_d;  oimm_q <= oimm_d;
      oopc_q <= oopc_d;  of3_q <= of3_d;  of7_q <= of7_d;  orob_q <= orob_d;
    end
  end

  assign out_valid   = ov_q;
  assign out_v1      = ov1_q;
  assign out_v2      = ov2_q;
  assign out_pc      = opc_out_q;
  assign out_imm     = oimm_q;
  assign out_opcode  = oopc_q;
  assign out_funct3  = of3_q;
  assign out_funct7b = of7_q;
  assign out_rob     = orob_q;
endmodule

// File: tb/tb_rs_issue_queue.sv
// tb/tb_rs_issue_queue.sv - directed table and sequence bench for rs_issue_queue
module tb_rs_issue_queue;
  logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1, rollback = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_q1_need = 1'b0, in_q2_need = 1'b0, in_funct7b;
  logic [31:0] in_v1 = '0, in_v2 = '0, in_pc, in_imm;
  logic [3:0]  in_q1 = '0, in_q2 = '0, in_rob = '0;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [1:0]  cdb_valid = '0;
  logic [7:0]  cdb_rob = '0;
  logic [63:0] cdb_value = '0;
  logic        out_valid, out_ready = 1'b1, out_funct7b;
  logic [31:0] out_v1, out_v2, out_pc, out_imm;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [3:0]  out_rob;
  logic [4:0]  occupancy;

  int n_chk = 0;
  int n_bad = 0;

  // Side fields are derived from the ROB tag so issued ops can be checked for them too.
  assign in_pc      = 32'h1000 + {26'd0, in_rob, 2'b00};
  assign in_imm     = {28'h5A5A000, in_rob};
  assign in_opcode  = 7'h33;
  assign in_funct3  = in_rob[2:0];
  assign in_funct7b = in_rob[0];

  rs_issue_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .in_valid(in_valid), .in_ready(in_ready), .in_v1(in_v1), .in_v2(in_v2),
    .in_q1(in_q1), .in_q2(in_q2), .in_q1_need(in_q1_need), .in_q2_need(in_q2_need),
    .in_pc(in_pc), .in_imm(in_imm), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7b(in_funct7b), .in_rob(in_rob),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_value(cdb_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_v1(out_v1), .out_v2(out_v2),
    .out_pc(out_pc), .out_imm(out_imm), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7b(out_funct7b), .out_rob(out_rob), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy, iv;
    logic [31:0] v1, v2;
    logic        q1n;
    logic [3:0]  q1;
    logic        q2n;
    logic [3:0]  q2, rob;
    logic [1:0]  cdbv;
    logic [3:0]  cr0;
    logic [31:0] cv0;
    logic [3:0]  cr1;
    logic [31:0] cv1;
    logic        ordy, e_ov;
    logic [4:0]  e_occ;
    logic        e_ir;
    logic [31:0] e_v1, e_v2;
    logic [3:0]  e_rob;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic iv, logic [31:0] v1, logic [31:0] v2,
                              logic q1n, logic [3:0] q1, logic q2n, logic [3:0] q2,
                              logic [3:0] rob, logic [1:0] cdbv, logic [3:0] cr0,
                              logic [31:0] cv0, logic [3:0] cr1, logic [31:0] cv1,
                              logic ordy, logic e_ov, logic [4:0] e_occ, logic e_ir,
                              logic [31:0] e_v1, logic [31:0] e_v2, logic [3:0] e_rob);
    vec_t t;
    t.rdy = r; t.iv = iv; t.v1 = v1; t.v2 = v2; t.q1n = q1n; t.q1 = q1; t.q2n = q2n;
    t.q2 = q2; t.rob = rob; t.cdbv = cdbv; t.cr0 = cr0; t.cv0 = cv0; t.cr1 = cr1;
    t.cv1 = cv1; t.ordy = ordy; t.e_ov = e_ov; t.e_occ = e_occ; t.e_ir = e_ir;
    t.e_v1 = e_v1; t.e_v2 = e_v2; t.e_rob = e_rob;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_op(input string nm, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [3:0] rob);
    chk({nm, ".ov"}, 32'(out_valid), 32'd1);
    chk({nm, ".v1"}, out_v1, v1);
    chk({nm, ".v2"}, out_v2, v2);
    chk({nm, ".rob"}, 32'(out_rob), 32'(rob));
    chk({nm, ".pc"}, out_pc, 32'h1000 + 32'(rob) * 4);
    chk({nm, ".side"}, {out_imm[3:0], out_opcode, out_funct3, out_funct7b},
        {rob, 7'h33, rob[2:0], rob[0]});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rdy = 1'b1; rollback = 1'b0; in_valid = 1'b0; in_q1_need = 1'b0; in_q2_need = 1'b0;
    cdb_valid = '0; out_ready = 1'b1;
  endtask

  task automatic disp(input logic [31:0] v1, input logic [31:0] v2, input logic q1n,
                      input logic [3:0] q1, input logic [3:0] rob);
    in_valid = 1'b1; in_v1 = v1; in_v2 = v2; in_q1_need = q1n; in_q1 = q1;
    in_q2_need = 1'b0; in_q2 = '0; in_rob = rob;
  endtask

  initial begin
    vec_t v;
    // rdy iv v1 v2 q1n q1 q2n q2 rob | cdbv cr0 cv0 cr1 cv1 | ordy | e_ov e_occ e_ir e_v1 e_v2 e_rob
    vecs.push_back(mk(1,1,5,7,0,0,0,0,3, 0,0,0,0,0, 1, 0,1,1, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0, 1, 1,0,1, 5,7,3));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0, 1, 0,0,1, 0,0,0));
    vecs.push_back(mk(1,1,1,0,0,0,1,4,5, 2'b01,4,9,0,0, 1, 0,1,1, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0, 1, 1,0,1, 1,9,5));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0, 1, 0,0,1, 0,0,0));
    vecs.push_back(mk(1,1,0,2,1,6,0,0,7, 0,6,32'h77,6,32'h77, 1, 0,1,1, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 2'b11,6,32'h11,6,32'h22, 1, 0,1,1, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0, 1, 1,0,1, 32'h11,2,7));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0, 1, 0,0,1, 0,0,0));
    vecs.push_back(mk(0,1,3,0,0,0,0,0,1, 0,0,0,0,0, 1, 0,0,0, 0,0,0));
    vecs.push_back(mk(1,1,3,0,0,0,0,0,1, 0,0,0,0,0, 1, 0,1,1, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0, 1, 0,1,0, 0,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0, 1, 1,0,1, 3,0,1));
    vecs.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0, 1, 1,0,0, 3,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0, 1, 0,0,1, 0,0,0));
    vecs.push_back(mk(1,1,32'hA,32'hB,0,0,0,0,10, 0,0,0,0,0, 1, 0,1,1, 0,0,0));
    vecs.push_back(mk(1,1,32'hC,32'hD,0,0,0,0,11, 0,0,0,0,0, 1, 1,1,1, 32'hA,32'hB,10));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0, 1, 1,0,1, 32'hC,32'hD,11));
    vecs.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0, 1, 0,0,1, 0,0,0));

    repeat (2) cyc();
    rst = 1'b0;
    chk("rst.ov", 32'(out_valid), 32'd0);
    chk("rst.occ", 32'(occupancy), 32'd0);
    chk("rst.ir", 32'(in_ready), 32'd1);
    chk("rst.data", out_v1 | out_v2 | 32'(out_rob), 32'd0);

    for (int s = 0; s < vecs.size(); s++) begin
      v = vecs[s];
      rdy = v.rdy; in_valid = v.iv; in_v1 = v.v1; in_v2 = v.v2; in_q1_need = v.q1n;
      in_q1 = v.q1; in_q2_need = v.q2n; in_q2 = v.q2; in_rob = v.rob; out_ready = v.ordy;
      cdb_valid = v.cdbv; cdb_rob = {v.cr1, v.cr0}; cdb_value = {v.cv1, v.cv0};
      cyc();
      chk($sformatf("vec%0d.ov", s), 32'(out_valid), 32'(v.e_ov));
      chk($sformatf("vec%0d.occ", s), 32'(occupancy), 32'(v.e_occ));
      chk($sformatf("vec%0d.ir", s), 32'(in_ready), 32'(v.e_ir));
      if (v.e_ov) chk_op($sformatf("vec%0d", s), v.e_v1, v.e_v2, v.e_rob);
    end

    // Late wakeup on channel 1, with a non-matching tag on channel 0.
    clr(); disp(0, 4, 1, 6, 2); cyc();
    chk("late.occ", 32'(occupancy), 32'd1);
    clr();
    for (int c = 0; c < 2; c++) begin
      cyc(); chk($sformatf("late.wait%0d", c), 32'(out_valid), 32'd0);
    end
    cdb_valid = 2'b11; cdb_rob = {4'd6, 4'd5}; cdb_value = {32'hDEAD, 32'h1};
    cyc(); chk("late.wake", 32'(out_valid), 32'd0);
    clr(); cyc();
    chk_op("late.issue", 32'hDEAD, 4, 2);
    chk("late.occ0", 32'(occupancy), 32'd0);
    cyc(); chk("late.drain", 32'(out_valid), 32'd0);

    // Fill all entries, attempt a 17th, then wake entry 9.
    clr();
    for (int i = 0; i < 16; i++) begin
      disp(i, 0, 1, 4'(i), 4'(i)); cyc();
    end
    chk("full.occ", 32'(occupancy), 32'd16);
    chk("full.ir", 32'(in_ready), 32'd0);
    disp(32'h77, 0, 0, 0, 0); cyc();
    chk("full.drop", 32'(occupancy), 32'd16);
    chk("full.ov", 32'(out_valid), 32'd0);
    in_valid = 1'b0; cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd9}; cdb_value = {32'h0, 32'h99};
    cyc();
    chk("full.wake_ir", 32'(in_ready), 32'd0);
    clr(); cyc();
    chk_op("full.issue", 32'h99, 0, 9);
    chk("full.occ15", 32'(occupancy), 32'd15);
    chk("full.ir1", 32'(in_ready), 32'd1);
    rollback = 1'b1; cyc(); clr();
    chk("full.flush", 32'(occupancy), 32'd0);

    // Entries 2 and 5 wake together while the ALU stalls.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      disp(i, 0, 1, (i == 2 || i == 5) ? 4'd14 : 4'd15, 4'(i)); cyc();
    end
    in_valid = 1'b0; cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd14}; cdb_value = {32'h0, 32'h55};
    cyc();
    chk("stall.pre", 32'(out_valid), 32'd0);
    clr(); out_ready = 1'b0; cyc();
    chk_op("stall.first", 32'h55, 0, 2);
    for (int c = 0; c < 4; c++) begin
      cyc();
      chk($sformatf("stall.hold%0d.rob", c), 32'(out_rob), 32'd2);
      chk($sformatf("stall.hold%0d.occ", c), 32'(occupancy), 32'd5);
    end
    out_ready = 1'b1; cyc();
    chk_op("stall.second", 32'h55, 0, 5);
    chk("stall.occ", 32'(occupancy), 32'd4);
    cyc(); chk("stall.empty", 32'(out_valid), 32'd0);

    // Rollback with ten waiting entries, a held output and a same-cycle dispatch.
    rollback = 1'b1; cyc(); clr();
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      disp(i, 0, (i != 0), 4'd15, 4'(i)); cyc();
    end
    chk("rb.occ10", 32'(occupancy), 32'd10);
    chk("rb.ov1", 32'(out_valid), 32'd1);
    disp(32'h44, 0, 0, 0, 12); rollback = 1'b1; out_ready = 1'b1; cyc();
    chk("rb.occ0", 32'(occupancy), 32'd0);
    chk("rb.ov0", 32'(out_valid), 32'd0);
    clr(); cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd15};
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk($sformatf("rb.after%0d.ov", c), 32'(out_valid), 32'd0);
      chk($sformatf("rb.after%0d.occ", c), 32'(occupancy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
